// File: rtl/semisumador_serial_ctrl.sv
// semisumador_serial_ctrl
// Bit-serial N-bit adder controller that time-shares one external,
// purely combinational half adder. Each operand bit takes two passes
// through the half adder:
//   PH1 : a_i + b_i            -> partial sum s1, carry c1
//   PH2 : s1 + stored carry    -> result bit, carry c2
// The carry stored for the next bit is c1 | c2.
//
// Handshake: START is accepted only on an edge where READY=1 (IDLE).
// A/B are sampled on that edge only. DONE pulses for one cycle in FIN,
// and S/CO are valid from that cycle until the next completion.
// START seen while READY=0 is dropped, not queued.
//
// Optional feature: define SEMISUM_OVF_EN to add output OVF, the signed
// two's-complement overflow of the last completed add, registered with S.
module semisumador_serial_ctrl #(
   parameter int N = 4
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         START,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         HA_S,
   input  logic         HA_C,
   output logic         HA_A,
   output logic         HA_B,
   output logic         READY,
   output logic         DONE,
   output logic [N-1:0] S,
`ifdef SEMISUM_OVF_EN
   output logic         CO,
   output logic         OVF
`else
   output logic         CO
`endif
);

   // idx only has to count to N-1; keep at least one bit for N=1
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PH1  = 2'd1,
      ST_PH2  = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

   state_e          state_q,  state_d;
   logic [N-1:0]    a_sh_q,   a_sh_d;
   logic [N-1:0]    b_sh_q,   b_sh_d;
   logic [N-1:0]    res_sh_q, res_sh_d;
   logic            carry_q,  carry_d;
   logic [IW-1:0]   idx_q,    idx_d;
   logic            s1_q,     s1_d;
   logic            c1_q,     c1_d;
   logic [N-1:0]    s_q,      s_d;
   logic            co_q,     co_d;
`ifdef SEMISUM_OVF_EN
   logic            ovf_q,    ovf_d;
`endif

   // State and datapath registers; async active-low reset clears everything
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         s1_q     <= 1'b0;
         c1_q     <= 1'b0;
         s_q      <= '0;
         co_q     <= 1'b0;
`ifdef SEMISUM_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         s1_q     <= s1_d;
         c1_q     <= c1_d;
         s_q      <= s_d;
         co_q     <= co_d;
`ifdef SEMISUM_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   // Next-state and datapath update; HA_S/HA_C are consumed in the same
   // cycle the operands are presented on HA_A/HA_B
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      s1_d     = s1_q;
      c1_d     = c1_q;
      s_d      = s_q;
      co_d     = co_q;
`ifdef SEMISUM_OVF_EN
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (START) begin
               a_sh_d   = A;
               b_sh_d   = B;
               carry_d  = 1'b0;
               idx_d    = '0;
               res_sh_d = '0;
               state_d  = ST_PH1;
            end
         end
         ST_PH1: begin
            s1_d    = HA_S;
            c1_d    = HA_C;
            state_d = ST_PH2;
         end
         ST_PH2: begin
            // result bits enter at the MSB so bit 0 lands at index 0 after N shifts
            res_sh_d         = res_sh_q >> 1;
            res_sh_d[N-1]    = HA_S;
            carry_d          = c1_q | HA_C;
            a_sh_d           = a_sh_q >> 1;
            b_sh_d           = b_sh_q >> 1;
            if (idx_q == IDX_LAST) begin
               s_d     = res_sh_d;
               co_d    = c1_q | HA_C;
`ifdef SEMISUM_OVF_EN
               // carry_q here is the carry into the MSB
               ovf_d   = carry_q ^ (c1_q | HA_C);
`endif
               state_d = ST_FIN;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_PH1;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore outputs and half-adder operand steering
   always_comb begin
      READY = 1'b0;
      DONE  = 1'b0;
      HA_A  = 1'b0;
      HA_B  = 1'b0;
      unique case (state_q)
         ST_IDLE: READY = 1'b1;
         ST_PH1: begin
            HA_A = a_sh_q[0];
            HA_B = b_sh_q[0];
         end
         ST_PH2: begin
            HA_A = s1_q;
            HA_B = carry_q;
         end
         ST_FIN:  DONE = 1'b1;
         default: READY = 1'b0;
      endcase
   end

   assign S  = s_q;
   assign CO = co_q;
`ifdef SEMISUM_OVF_EN
   assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_semisumador_serial_ctrl.sv
// Testbench for semisumador_serial_ctrl: one N=4 instance and one N=1
// instance, each with its own combinational half-adder model.
// Optional OVF checks are compiled in when SEMISUM_OVF_EN is defined.
module tb_semisumador_serial_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- N=4 instance ----------------
  logic       start4;
  logic [3:0] a4, b4, s4;
  logic       ha_a4, ha_b4, ha_s4, ha_c4, ready4, done4, co4;
  logic       ovf4;

  // ---------------- N=1 instance ----------------
  logic       start1;
  logic [0:0] a1, b1, s1;
  logic       ha_a1, ha_b1, ha_s1, ha_c1, ready1, done1, co1;
  logic       ovf1;

  assign ha_s4 = ha_a4 ^ ha_b4;
  assign ha_c4 = ha_a4 & ha_b4;
  assign ha_s1 = ha_a1 ^ ha_b1;
  assign ha_c1 = ha_a1 & ha_b1;

  semisumador_serial_ctrl #(.N(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .START(start4), .A(a4), .B(b4),
    .HA_S(ha_s4), .HA_C(ha_c4), .HA_A(ha_a4), .HA_B(ha_b4),
    .READY(ready4), .DONE(done4), .S(s4),
`ifdef SEMISUM_OVF_EN
    .CO(co4), .OVF(ovf4)
`else
    .CO(co4)
`endif
  );

  semisumador_serial_ctrl #(.N(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .A(a1), .B(b1),
    .HA_S(ha_s1), .HA_C(ha_c1), .HA_A(ha_a1), .HA_B(ha_b1),
    .READY(ready1), .DONE(done1), .S(s1),
`ifdef SEMISUM_OVF_EN
    .CO(co1), .OVF(ovf1)
`else
    .CO(co1)
`endif
  );

`ifndef SEMISUM_OVF_EN
  assign ovf4 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  // selected instance view
  logic       sel1;
  logic       cur_ready, cur_done, cur_ha_a, cur_ha_b, cur_co, cur_ovf;
  logic [3:0] cur_s;
  always_comb begin
    cur_ready = sel1 ? ready1 : ready4;
    cur_done  = sel1 ? done1  : done4;
    cur_ha_a  = sel1 ? ha_a1  : ha_a4;
    cur_ha_b  = sel1 ? ha_b1  : ha_b4;
    cur_co    = sel1 ? co1    : co4;
    cur_ovf   = sel1 ? ovf1   : ovf4;
    cur_s     = sel1 ? {3'b000, s1} : s4;
  end

  // ---------------- scoreboard ----------------
  int n_compared = 0;
  int n_mismatch = 0;
  int prev_s[2], prev_co[2], prev_ovf[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain unsigned arithmetic on n-bit operands
  function automatic void model(input int n, input int a, input int b,
                                output int s, output int co, output int ovf);
    int sum;
    sum = a + b;
    s   = sum % (1 << n);
    co  = sum >> n;
    ovf = (((a >> (n-1)) & 1) == ((b >> (n-1)) & 1)) &&
          (((s >> (n-1)) & 1) != ((a >> (n-1)) & 1)) ? 1 : 0;
  endfunction

  task automatic drive_start(input bit use1, input bit v, input int a, input int b);
    if (use1) begin
      start1 = v; a1 = a[0]; b1 = b[0];
    end else begin
      start4 = v; a4 = a[3:0]; b4 = b[3:0];
    end
  endtask

  // One full add: wait for READY, accept, then check every cycle up to and
  // including FIN and the first IDLE cycle. Half-adder operand pairs are
  // derived from the operands: PH1 presents (a_i, b_i), PH2 presents
  // (a_i ^ b_i, carry into bit i).
  task automatic run_add(input bit use1, input int a, input int b,
                         input int exp_s, input int exp_co, input int exp_ovf,
                         input int poke_m, input bit b2b);
    int n, waitc, i, cin, mask;
    logic [1:0] exp_ha;
    n = use1 ? 1 : 4;
    sel1 = use1;
    waitc = 0;
    #0;
    while (!cur_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (b2b) check("b2b_ready_wait", waitc, 0);
    else if (waitc >= 50) check("ready_timeout", 0, 1);
    drive_start(use1, 1'b1, a, b);
    @(posedge clk);
    #1;
    // operands changing after the accepting edge must not matter
    drive_start(use1, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15));
    for (int m = 0; m <= 2*n; m++) begin
      @(negedge clk);
      if (m == poke_m) drive_start(use1, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15));
      else if (use1) start1 = 1'b0;
      else start4 = 1'b0;
      #1;
      check("busy_ready", cur_ready, 0);
      check("done_timing", cur_done, (m == 2*n) ? 1 : 0);
      if (m == 2*n) begin
        exp_ha = 2'b00;
      end else begin
        i = m / 2;
        mask = (1 << i) - 1;
        cin = ((a & mask) + (b & mask)) >> i;
        if (m % 2 == 0) exp_ha = {a[i], b[i]};
        else exp_ha = {a[i] ^ b[i], cin[0]};
      end
      check("ha_pair", {cur_ha_a, cur_ha_b}, exp_ha);
      if (m < 2*n) begin
        check("s_hold_busy", cur_s, prev_s[use1]);
        check("co_hold_busy", cur_co, prev_co[use1]);
      end else begin
        check("sum", cur_s, exp_s);
        check("carry_out", cur_co, exp_co);
`ifdef SEMISUM_OVF_EN
        check("ovf", cur_ovf, exp_ovf);
`endif
      end
    end
    if (use1) start1 = 1'b0; else start4 = 1'b0;
    @(negedge clk);
    #1;
    check("done_pulse_end", cur_done, 0);
    check("ready_after", cur_ready, 1);
    check("s_held_idle", cur_s, exp_s);
    prev_s[use1]   = exp_s;
    prev_co[use1]  = exp_co;
    prev_ovf[use1] = exp_ovf;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       co;
    logic       ovf;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int rs, rco, rovf, ra, rb;
    bit saw_done;
    vecs[0] = '{a: 4'd3,  b: 4'd5,  s: 4'd8,  co: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 4'd15, b: 4'd1,  s: 4'd0,  co: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  s: 4'd0,  co: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 4'd7,  b: 4'd1,  s: 4'd8,  co: 1'b0, ovf: 1'b1};
    vecs[4] = '{a: 4'd6,  b: 4'd7,  s: 4'd13, co: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 4'd9,  b: 4'd9,  s: 4'd2,  co: 1'b1, ovf: 1'b1};
    vecs[6] = '{a: 4'd8,  b: 4'd8,  s: 4'd0,  co: 1'b1, ovf: 1'b1};
    vecs[7] = '{a: 4'd5,  b: 4'd10, s: 4'd15, co: 1'b0, ovf: 1'b0};
    vecs[8] = '{a: 4'd12, b: 4'd3,  s: 4'd15, co: 1'b0, ovf: 1'b0};

    sel1 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    for (int k = 0; k < 2; k++) begin
      prev_s[k] = 0; prev_co[k] = 0; prev_ovf[k] = 0;
    end

    // reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", ready4, 1);
    check("rst_done", done4, 0);
    check("rst_s", s4, 0);
    check("rst_co", co4, 0);
    check("rst_ha", {ha_a4, ha_b4}, 0);
    check("rst_ready_n1", ready1, 1);
    check("rst_s_n1", {s1, co1}, 0);
`ifdef SEMISUM_OVF_EN
    check("rst_ovf", ovf4, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // table: each add after the first starts back-to-back
    for (int v = 0; v < 9; v++)
      run_add(1'b0, vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].co, vecs[v].ovf, -1, v > 0);

    // START pulsed at cycle 3 of an add is ignored
    run_add(1'b0, 3, 5, 8, 0, 1, 3, 1'b0);
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (done4 || s4 !== 4'd8) saw_done = 1'b1;
    end
    check("ignored_start_no_extra_done", saw_done, 0);

    // N=1: 1+1 -> S=0, CO=1 after 2 cycles
    run_add(1'b1, 1, 1, 0, 1, 1, -1, 1'b0);

    // reset during PH2 of bit 2 (sixth cycle after acceptance)
    sel1 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("pre_rst_ph2_ha", {ha_a4, ha_b4}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ready", ready4, 1);
    check("midrst_s", s4, 0);
    check("midrst_co", co4, 0);
    check("midrst_done", done4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_s[0] = 0; prev_co[0] = 0; prev_ovf[0] = 0;
    prev_s[1] = 0; prev_co[1] = 0; prev_ovf[1] = 0;
    saw_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (done4) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);
    run_add(1'b0, 6, 7, 13, 0, 1, -1, 1'b0);

    // randomized stimulus against the arithmetic model
    for (int r = 0; r < 30; r++) begin
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      model(4, ra, rb, rs, rco, rovf);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_add(1'b0, ra, rb, rs, rco, rovf, $urandom_range(0, 9), 1'b0);
    end
    for (int r = 0; r < 8; r++) begin
      ra = $urandom_range(0, 1);
      rb = $urandom_range(0, 1);
      model(1, ra, rb, rs, rco, rovf);
      run_add(1'b1, ra, rb, rs, rco, rovf, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
